// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared types and helpers for the vga_stream video output stage
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Width of the saturating error event counter
  localparam int ERR_CNT_W = 16;

  // Stream alignment state machine
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Total period of one raster axis (porches + pulse + visible)
  function automatic int timing_total(input int fp, input int pulse,
                                      input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_stream_if
//  Purpose  : Pixel FIFO head handshake between upstream buffer and video out
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_stream_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] pix_data;   // head-of-FIFO pixel
  logic              pix_sof;    // head pixel is (0,0) of a frame
  logic              pix_valid;  // FIFO not empty
  logic              pix_ready;  // consume head pixel this cycle
  logic              fill_ok;    // FIFO prefill level reached

  modport master (output pix_data, pix_sof, pix_valid, fill_ok, input pix_ready);
  modport slave  (input pix_data, pix_sof, pix_valid, fill_ok, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Free-running raster counters with sync/active decode and
//             active-region coordinate translation
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing import vga_pkg::*; #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic                      hsync_o,      // raw sync region, polarity applied later
  output logic                      vsync_o,
  output logic                      active_o,
  output logic                      frame_end_o,  // last cycle of the frame
  output logic                      first_px_o,   // active pixel (0,0)
  output logic [$clog2(HDISP)-1:0]  x_o,
  output logic [$clog2(VDISP)-1:0]  y_o
);
  localparam int HTOTAL = timing_total(HFP, HPULSE, HBP, HDISP);
  localparam int VTOTAL = timing_total(VFP, VPULSE, VBP, VDISP);
  localparam int HCNT_W = $clog2(HTOTAL);
  localparam int VCNT_W = $clog2(VTOTAL);
  localparam int X_W    = $clog2(HDISP);
  localparam int Y_W    = $clog2(VDISP);

  localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(HTOTAL - 1);
  localparam logic [HCNT_W-1:0] H_SYNC_ON  = HCNT_W'(HFP);
  localparam logic [HCNT_W-1:0] H_SYNC_OFF = HCNT_W'(HFP + HPULSE);
  localparam logic [HCNT_W-1:0] H_ACT      = HCNT_W'(HFP + HPULSE + HBP);
  localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(VTOTAL - 1);
  localparam logic [VCNT_W-1:0] V_SYNC_ON  = VCNT_W'(VFP);
  localparam logic [VCNT_W-1:0] V_SYNC_OFF = VCNT_W'(VFP + VPULSE);
  localparam logic [VCNT_W-1:0] V_ACT      = VCNT_W'(VFP + VPULSE + VBP);

  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
  logic              h_wrap_w;

  assign h_wrap_w = (h_cnt_q == H_LAST);

  // Next counter values: h wraps every line, v advances on each h wrap
  always_comb begin
    h_cnt_d = h_wrap_w ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap_w) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Raster counters, free-running from reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync_o     = (h_cnt_q >= H_SYNC_ON) && (h_cnt_q < H_SYNC_OFF);
  assign vsync_o     = (v_cnt_q >= V_SYNC_ON) && (v_cnt_q < V_SYNC_OFF);
  assign active_o    = (h_cnt_q >= H_ACT) && (v_cnt_q >= V_ACT);
  assign frame_end_o = h_wrap_w && (v_cnt_q == V_LAST);
  assign first_px_o  = (h_cnt_q == H_ACT) && (v_cnt_q == V_ACT);
  assign x_o         = active_o ? X_W'(h_cnt_q - H_ACT) : '0;
  assign y_o         = active_o ? Y_W'(v_cnt_q - V_ACT) : '0;

endmodule
`default_nettype wire

// File: rtl/vga_stream.sv
`default_nettype none
// ============================================================================
//  Module   : vga_stream
//  Purpose  : Video output stage: raster timing plus frame-aligned pixel
//             stream consumer with underflow/misalignment resync
//  Revision : 1.0 - initial release
// ============================================================================
module vga_stream import vga_pkg::*; #(
  parameter int               HDISP     = 800,
  parameter int               VDISP     = 480,
  parameter int               HFP       = 40,
  parameter int               HPULSE    = 48,
  parameter int               HBP       = 40,
  parameter int               VFP       = 13,
  parameter int               VPULSE    = 3,
  parameter int               VBP       = 29,
  parameter bit               HS_POL    = 1'b0,
  parameter bit               VS_POL    = 1'b0,
  parameter int               DATA_W    = 24,
  parameter logic [DATA_W-1:0] ERR_COLOR = DATA_W'(24'hFF00FF)
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic                     enable,
  vga_stream_if.slave              pix,
  output logic                     HS,
  output logic                     VS,
  output logic                     BLANK,
  output logic [DATA_W-1:0]        RGB,
  output logic [$clog2(HDISP)-1:0] x_pos,
  output logic [$clog2(VDISP)-1:0] y_pos,
  output logic                     frame_start,
  output logic                     underflow,
  output logic [ERR_CNT_W-1:0]     err_cnt
);
  logic                     hsync_w, vsync_w, active_w, frame_end_w, first_px_w;
  logic [$clog2(HDISP)-1:0] x_w;
  logic [$clog2(VDISP)-1:0] y_w;

  state_t                   state_q, state_d;
  logic                     ready_w, err_w, fs_d;
  logic [DATA_W-1:0]        rgb_d;
  logic [ERR_CNT_W-1:0]     err_cnt_d;

  vga_timing #(
    .HDISP(HDISP), .VDISP(VDISP),
    .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .clk_i       (pixel_clk),
    .rst_n_i     (pixel_rst_n),
    .hsync_o     (hsync_w),
    .vsync_o     (vsync_w),
    .active_o    (active_w),
    .frame_end_o (frame_end_w),
    .first_px_o  (first_px_w),
    .x_o         (x_w),
    .y_o         (y_w)
  );

  // State register
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next state: enable low always parks in IDLE; an error in RUN restarts the search
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SEEK;
        SEEK:    if (pix.pix_valid && pix.pix_sof && pix.fill_ok) state_d = ARMED;
        ARMED:   if (frame_end_w) state_d = RUN;
        RUN:     if (err_w) state_d = SEEK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and pixel selection; with enable low nothing is consumed and no error is raised
  always_comb begin
    ready_w   = 1'b0;
    err_w     = 1'b0;
    fs_d      = 1'b0;
    rgb_d     = '0;
    case (state_q)
      SEEK: ready_w = enable && pix.pix_valid && !pix.pix_sof;
      RUN: begin
        if (enable && active_w) begin
          if (!pix.pix_valid || (pix.pix_sof != first_px_w)) begin
            err_w = 1'b1;
            rgb_d = ERR_COLOR;
          end else begin
            ready_w = 1'b1;
            rgb_d   = pix.pix_data;
            fs_d    = first_px_w;
          end
        end
      end
      default: ;
    endcase
    err_cnt_d = (err_w && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
  end

  assign pix.pix_ready = ready_w;

  // Output registers: every output lags the counters and handshake by one cycle
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      BLANK       <= 1'b0;
      RGB         <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      HS          <= hsync_w ? HS_POL : ~HS_POL;
      VS          <= vsync_w ? VS_POL : ~VS_POL;
      BLANK       <= active_w;
      RGB         <= rgb_d;
      x_pos       <= x_w;
      y_pos       <= y_w;
      frame_start <= fs_d;
      underflow   <= err_w;
      err_cnt     <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_stream
//  Purpose  : Self-checking bench for vga_stream (8x4 visible, 14x7 total)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_stream;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam logic [23:0] ERRC = 24'hFF00FF;

  typedef struct { logic [23:0] d; bit sof; } word_t;
  typedef struct { logic [23:0] rgb; int x; int y; bit fs; } px_t;
  typedef struct { int c; logic hs; logic vs; logic bl; logic [2:0] x; logic [1:0] y; } tv_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        HS, VS, BLANK, fs, uf;
  logic [23:0] RGB;
  logic [2:0]  xp;
  logic [1:0]  yp;
  logic [15:0] ec;

  vga_stream_if #(.DATA_W(24)) pix ();

  vga_stream #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .DATA_W(24), .ERR_COLOR(24'hFF00FF)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(en), .pix(pix),
    .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB), .x_pos(xp), .y_pos(yp),
    .frame_start(fs), .underflow(uf), .err_cnt(ec)
  );

  always #5 clk = ~clk;

  int    errors = 0, checks = 0;
  int    cyc = 0, consumed = 0, exp_err = 0, blank_seen = 0;
  int    en_on = -1, en_off = -1, drop_cyc = -1, uf_a = -1, uf_b = -1;
  int    gen_k = 0, gen_pos = 0;
  int    inj_k = 117;
  word_t fifo[$];
  px_t   sb[$];
  tv_t   tab[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pixel cycle %0d)", name, act, exp, cyc - 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sync"}, {30'd0, HS, VS}, 32'd3);
    chk({tag, "_outs"}, {2'b0, BLANK, RGB, xp, yp, fs, uf}, 32'd0);
    chk({tag, "_errcnt"}, {16'd0, ec}, 32'd0);
    chk({tag, "_ready"}, {31'd0, pix.pix_ready}, 32'd0);
  endtask

  // Keep the upstream FIFO topped up; sof every 32 words, plus one injected early sof
  task automatic refill();
    word_t w;
    while (fifo.size() < 48) begin
      w.d     = 24'(32'h100000 + gen_k);
      w.sof   = (gen_pos == 0) || (gen_k == inj_k);
      gen_pos = w.sof ? 1 : (gen_pos + 1) % 32;
      gen_k++;
      fifo.push_back(w);
    end
  endtask

  // Expected visible output for one frame: words first.. up to stop, optional error pixel
  task automatic push_frame(input int first, input int stop, input int errp);
    px_t e;
    for (int p = 0; p < 32; p++) begin
      e.x = p % 8; e.y = p / 8; e.fs = 1'b0; e.rgb = '0;
      if (first >= 0 && p < stop) begin
        e.rgb = 24'(32'h100000 + first + p);
        e.fs  = (p == 0);
      end else if (p == errp) begin
        e.rgb = ERRC;
      end
      sb.push_back(e);
    end
  endtask

  // One pixel clock: drive FIFO head, handshake, then check the registered outputs
  task automatic tick();
    int  c, h, v;
    bit  act, took;
    px_t e;
    if (cyc == en_on)  en = 1'b1;
    if (cyc == en_off) en = 1'b0;
    if (fifo.size() > 0) begin
      pix.pix_data  = fifo[0].d;
      pix.pix_sof   = fifo[0].sof;
      pix.pix_valid = (cyc != drop_cyc);
    end else begin
      pix.pix_data = '0; pix.pix_sof = 1'b0; pix.pix_valid = 1'b0;
    end
    #2;
    took = pix.pix_ready && pix.pix_valid;
    @(posedge clk);
    if (took) begin
      void'(fifo.pop_front());
      consumed++;
      refill();
    end
    cyc++;
    @(negedge clk);
    c = cyc - 1; h = c % HT; v = (c / HT) % VT;
    act = (h >= 6) && (v >= 3);
    if (c == uf_a || c == uf_b) exp_err++;
    chk("HS", {31'd0, HS}, {31'd0, !(h >= 2 && h < 4)});
    chk("VS", {31'd0, VS}, {31'd0, (v != 1)});
    chk("BLANK", {31'd0, BLANK}, {31'd0, act});
    chk("underflow", {31'd0, uf}, {31'd0, (c == uf_a || c == uf_b)});
    chk("err_cnt", {16'd0, ec}, exp_err);
    if (c < FT && BLANK) blank_seen++;
    if (act) begin
      if (sb.size() == 0) chk("sb_underrun", sb.size(), 32'd1);
      else begin
        e = sb.pop_front();
        chk("RGB", {8'd0, RGB}, {8'd0, e.rgb});
        chk("x_pos", {29'd0, xp}, e.x);
        chk("y_pos", {30'd0, yp}, e.y);
        chk("frame_start", {31'd0, fs}, {31'd0, e.fs});
      end
    end else begin
      chk("blank_outs", {8'd0, RGB, xp, yp, fs}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    fifo.delete(); sb.delete();
    cyc = 0; exp_err = 0; consumed = 0; blank_seen = 0;
    en_on = -1; en_off = -1; drop_cyc = -1; uf_a = -1; uf_b = -1;
    pix.pix_valid = 1'b0; pix.pix_sof = 1'b0; pix.pix_data = '0;
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pix.fill_ok = 1'b1;
    // {pixel cycle, HS, VS, BLANK, x, y} for a stream-less frame
    tab[0]  = '{0,   1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[1]  = '{2,   1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[2]  = '{3,   1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[3]  = '{4,   1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[4]  = '{14,  1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
    tab[5]  = '{16,  1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    tab[6]  = '{28,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[7]  = '{47,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[8]  = '{48,  1'b1, 1'b1, 1'b1, 3'd0, 2'd0};
    tab[9]  = '{55,  1'b1, 1'b1, 1'b1, 3'd7, 2'd0};
    tab[10] = '{56,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[11] = '{72,  1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
    tab[12] = '{83,  1'b1, 1'b1, 1'b1, 3'd7, 2'd2};
    tab[13] = '{97,  1'b1, 1'b1, 1'b1, 3'd7, 2'd3};
    tab[14] = '{114, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0};

    // Timing only, stream disabled
    do_reset();
    push_frame(-1, 0, -1);
    push_frame(-1, 0, -1);
    for (int i = 0; i < 15; i++) begin
      while (cyc < tab[i].c + 1) tick();
      chk("tab_sync", {30'd0, HS, VS}, {30'd0, tab[i].hs, tab[i].vs});
      chk("tab_blank", {31'd0, BLANK}, {31'd0, tab[i].bl});
      chk("tab_xy", {27'd0, xp, yp}, {27'd0, tab[i].x, tab[i].y});
    end
    chk("blank_count", blank_seen, 32'd32);

    // Streaming: stale drain, clean frame, underflow, misalignment, enable drop
    do_reset();
    for (int i = 0; i < 3; i++) fifo.push_back('{24'(32'hDEAD00 + i), 1'b0});
    gen_k = 0; gen_pos = 0;
    refill();
    en_on    = 5;
    drop_cyc = 2 * FT + 4 * HT + 9;   // pixel (3,1) of frame 2
    uf_a     = drop_cyc;
    uf_b     = 4 * FT + 5 * HT + 11;  // pixel (5,2) of frame 4, word 117 carries sof
    en_off   = 6 * FT + 5 * HT + 9;   // pixel (3,2) of frame 6
    push_frame(-1,  0,  -1);
    push_frame(0,   32, -1);
    push_frame(32,  11, 11);
    push_frame(64,  32, -1);
    push_frame(96,  21, 21);
    push_frame(117, 32, -1);
    push_frame(149, 19, -1);
    while (cyc < FT) tick();
    chk("stale_drained", consumed, 32'd3);
    while (cyc < 2 * FT) tick();
    chk("frame1_consumed", consumed, 32'd35);
    while (cyc < en_off + 20) tick();
    chk("no_err_on_disable", {16'd0, ec}, 32'd2);

    // Asynchronous reset mid-frame, away from any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    check_reset_vals("held_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
